// File: rtl/pingpong_write_if.sv
// Write-side bus between the ping-pong write sequencer and its environment.
// Carries the incoming sample stream, the RAM port-A write signals and status.
//
// Handshake semantics: the sample stream is valid-only with no backpressure.
// A sample is presented for exactly the cycles sample_valid is high and is
// either written or discarded, never stalled. readya is a level-sensitive
// grant from the RAM: sampled high in WAIT_RDY it hands one bank to the writer
// for one complete frame, which is returned with a single-cycle finisha pulse.
interface pingpong_write_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
);
    logic              enable;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              readya;
    logic [ADDR_W-1:0] addra;
    logic              wea;
    logic [DATA_W-1:0] dina;
    logic              finisha;
    logic              busy;
    logic [15:0]       frame_cnt;
    logic [15:0]       drop_cnt;

    // Sequencer side
    modport master (
        input  enable, sample_valid, sample_data, readya,
        output addra, wea, dina, finisha, busy, frame_cnt, drop_cnt
    );

    // Environment side (sample source, RAM, status consumer)
    modport slave (
        output enable, sample_valid, sample_data, readya,
        input  addra, wea, dina, finisha, busy, frame_cnt, drop_cnt
    );
endinterface

// File: rtl/pingpong_write_ctrl.sv
// Write-side sequencer for a ping-pong RAM. Packs a free-running sample stream
// into DEPTH-sample frames written through port A, pulses finisha per frame
// and counts samples dropped while no bank is free.
// Optional build macro FRAME_TRIG_EN: adds an ARM state that starts each frame
// on a rising crossing of TRIG_LEVEL instead of on the first valid sample.
module pingpong_write_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 7,
    parameter int DEPTH      = 128,
    parameter int TRIG_LEVEL = 128
) (
    input  logic                 clk_in,
    input  logic                 rst,
    pingpong_write_if.master     bus,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_FILL     = 3'd2,
        S_FINISH   = 3'd3,
        S_HOLD     = 3'd4,
        S_ARM      = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [DATA_W-1:0] dina_q, dina_d;
    logic              wea_q, wea_d;
    logic              finisha_q, finisha_d;
    logic              busy_q, busy_d;
    logic [15:0]       frame_q, frame_d;
    logic [15:0]       drop_q, drop_d;

`ifdef FRAME_TRIG_EN
    localparam logic [DATA_W-1:0] TRIG = DATA_W'(TRIG_LEVEL);
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              trig_hit;

    // Rising crossing of the trigger level on the current valid sample
    assign trig_hit = bus.sample_valid && (prev_q < TRIG) && (bus.sample_data >= TRIG);
`endif

    // State register
    always_ff @(posedge clk_in) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (bus.enable) state_d = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (!bus.enable)     state_d = S_IDLE;
`ifdef FRAME_TRIG_EN
                else if (bus.readya) state_d = S_ARM;
`else
                else if (bus.readya) state_d = S_FILL;
`endif
            end
            // enable is ignored here: a granted bank is always filled completely
            S_FILL:     if (bus.sample_valid && cnt_q == LAST_ADDR) state_d = S_FINISH;
            S_FINISH:   state_d = S_HOLD;
            S_HOLD:     state_d = bus.enable ? S_WAIT_RDY : S_IDLE;
`ifdef FRAME_TRIG_EN
            S_ARM: begin
                if (!bus.enable)   state_d = S_IDLE;
                else if (trig_hit) state_d = S_FILL;
            end
`endif
            default:    state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        cnt_d     = cnt_q;
        addra_d   = addra_q;
        dina_d    = dina_q;
        wea_d     = 1'b0;
        frame_d   = frame_q;
        drop_d    = drop_q;
        // finisha lands in the cycle after FINISH, two cycles after the last sample
        finisha_d = (state_q == S_FINISH);
        busy_d    = (state_d == S_FILL) || (state_d == S_FINISH) || (state_d == S_ARM);
`ifdef FRAME_TRIG_EN
        prev_d    = prev_q;
`endif
        case (state_q)
            S_WAIT_RDY: begin
                cnt_d = '0;
`ifdef FRAME_TRIG_EN
                prev_d = '0;
`endif
                if (bus.sample_valid && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end
            S_FILL: begin
                if (bus.sample_valid) begin
                    wea_d   = 1'b1;
                    addra_d = cnt_q;
                    dina_d  = bus.sample_data;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_FINISH: frame_d = frame_q + 16'd1;
`ifdef FRAME_TRIG_EN
            S_ARM: begin
                if (bus.sample_valid) begin
                    if (bus.enable && trig_hit) begin
                        wea_d   = 1'b1;
                        addra_d = '0;
                        dina_d  = bus.sample_data;
                        cnt_d   = ADDR_W'(1);
                    end else begin
                        prev_d = bus.sample_data;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q     <= '0;
            addra_q   <= '0;
            dina_q    <= '0;
            wea_q     <= 1'b0;
            finisha_q <= 1'b0;
            busy_q    <= 1'b0;
            frame_q   <= '0;
            drop_q    <= '0;
`ifdef FRAME_TRIG_EN
            prev_q    <= '0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            addra_q   <= addra_d;
            dina_q    <= dina_d;
            wea_q     <= wea_d;
            finisha_q <= finisha_d;
            busy_q    <= busy_d;
            frame_q   <= frame_d;
            drop_q    <= drop_d;
`ifdef FRAME_TRIG_EN
            prev_q    <= prev_d;
`endif
        end
    end

    assign bus.addra     = addra_q;
    assign bus.wea       = wea_q;
    assign bus.dina      = dina_q;
    assign bus.finisha   = finisha_q;
    assign bus.busy      = busy_q;
    assign bus.frame_cnt = frame_q;
    assign bus.drop_cnt  = drop_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_pingpong_write_ctrl.sv
// Self-checking bench for pingpong_write_ctrl. Expected RAM writes are queued
// as samples are driven and matched against wea cycles by a monitor.
module tb_pingpong_write_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;
    localparam int W      = ADDR_W + DATA_W;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_FILL   = 3'd2;
    localparam logic [2:0] ST_ARM    = 3'd5;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int fin_count = 0;

    logic [W-1:0] exp_q[$];

    pingpong_write_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    pingpong_write_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TRIG_LEVEL(128)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: every write must match the head of the expected queue
    always @(negedge clk_in) begin
        if (bus.finisha === 1'b1) fin_count++;
        if (bus.wea === 1'b1) begin
            check("addra_range", 32'(bus.addra <= ADDR_W'(DEPTH - 1)), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_wea", 32'(bus.wea), 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.addra), 32'(e[W-1:DATA_W]));
                check("write_data", 32'(bus.dina), 32'(e[DATA_W-1:0]));
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
    endtask

    task automatic drive_sample(input logic [DATA_W-1:0] d);
        bus.sample_valid = 1'b1;
        bus.sample_data  = d;
        step();
        idle_inputs();
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        int n = 0;
        while (state_dbg !== target && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(state_dbg), 32'(target));
    endtask

    // Called right after the edge that sampled the last sample of a frame
    task automatic finish_check(input logic [15:0] exp_frames, input string tag);
        check({tag, "_fin_early"}, 32'(bus.finisha), 32'd0);
        step();
        check({tag, "_fin_pulse"}, 32'(bus.finisha), 32'd1);
        check({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'(exp_frames));
        step();
        check({tag, "_fin_single"}, 32'(bus.finisha), 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        int wr;

        bus.enable = 1'b0;
        bus.readya = 1'b0;
        idle_inputs();

        // Reset for 10 cycles
        rst = 1'b1;
        repeat (10) step();
        check("rst_addra",   32'(bus.addra), 32'd0);
        check("rst_wea",     32'(bus.wea), 32'd0);
        check("rst_dina",    32'(bus.dina), 32'd0);
        check("rst_finisha", 32'(bus.finisha), 32'd0);
        check("rst_busy",    32'(bus.busy), 32'd0);
        check("rst_frames",  32'(bus.frame_cnt), 32'd0);
        check("rst_drops",   32'(bus.drop_cnt), 32'd0);
        check("rst_state",   32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;

        // Test 1: back-to-back ramp 0..127
        bus.enable = 1'b1;
        bus.readya = 1'b1;
        wait_state(ST_FILL, 20, "t1_enter_fill");
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back({ADDR_W'(i), DATA_W'(i)});
            drive_sample(DATA_W'(i));
            if (i == 5) check("t1_busy", 32'(bus.busy), 32'd1);
        end
        finish_check(16'd1, "t1");
        check("t1_fin_count", 32'(fin_count), 32'd1);

        // Test 2: valid every other cycle, readya drops mid-frame
        wait_state(ST_FILL, 20, "t2_enter_fill");
        wr = 0;
        for (int k = 0; k < 2 * DEPTH; k++) begin
            if (k == 100) bus.readya = 1'b0;
            if (k % 2 == 1) begin
                d = DATA_W'($urandom_range(0, 255));
                exp_q.push_back({ADDR_W'(wr), d});
                wr++;
                drive_sample(d);
            end else begin
                step();
            end
        end
        finish_check(16'd2, "t2");
        check("t2_drops", 32'(bus.drop_cnt), 32'd0);

        // Test 3: 20 samples dropped while no bank is free
        wait_state(ST_WAIT, 20, "t3_wait_rdy");
        for (int j = 0; j < 20; j++) drive_sample(DATA_W'(200 + j));
        check("t3_drops", 32'(bus.drop_cnt), 32'd20);
        bus.readya = 1'b1;
        step();
        check("t3_enter_fill", 32'(state_dbg), 32'(ST_FILL));

        // Test 4: frame from the 21st sample, reset once addra reaches 60
        for (int i = 0; i <= 60; i++) begin
            d = DATA_W'(220 + i);
            exp_q.push_back({ADDR_W'(i), d});
            drive_sample(d);
        end
        check("t4_addra60", 32'(bus.addra), 32'd60);
        rst = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'hAA;
        step();
        idle_inputs();
        check("t4_rst_addra",   32'(bus.addra), 32'd0);
        check("t4_rst_wea",     32'(bus.wea), 32'd0);
        check("t4_rst_dina",    32'(bus.dina), 32'd0);
        check("t4_rst_finisha", 32'(bus.finisha), 32'd0);
        check("t4_rst_busy",    32'(bus.busy), 32'd0);
        check("t4_rst_frames",  32'(bus.frame_cnt), 32'd0);
        check("t4_rst_drops",   32'(bus.drop_cnt), 32'd0);
        rst = 1'b0;
        repeat (3) step();
        check("t4_no_finisha", 32'(fin_count), 32'd2);

        // Test 5: restart at addra 0, enable dropped at addra 10
        wait_state(ST_FILL, 20, "t5_enter_fill");
        for (int i = 0; i < DEPTH; i++) begin
            d = DATA_W'($urandom_range(0, 255));
            exp_q.push_back({ADDR_W'(i), d});
            drive_sample(d);
            if (i == 10) begin
                check("t5_addra10", 32'(bus.addra), 32'd10);
                bus.enable = 1'b0;
            end
        end
        finish_check(16'd1, "t5");
        check("t5_idle", 32'(state_dbg), 32'(ST_IDLE));
        for (int j = 0; j < 30; j++) drive_sample(DATA_W'(j));
        check("t5_stay_idle", 32'(state_dbg), 32'(ST_IDLE));
        check("t5_busy_low", 32'(bus.busy), 32'd0);
        check("t5_drops", 32'(bus.drop_cnt), 32'd0);
        check("t5_fin_count", 32'(fin_count), 32'd3);

`ifdef FRAME_TRIG_EN
        // Test 6: trigger on rising crossing of 128 in ramp 100..200
        bus.enable = 1'b1;
        wait_state(ST_ARM, 20, "t6_enter_arm");
        wr = 0;
        for (int v = 100; v <= 200; v += 10) begin
            if (v >= 130) begin
                exp_q.push_back({ADDR_W'(wr), DATA_W'(v)});
                wr++;
            end
            drive_sample(DATA_W'(v));
        end
        while (wr < DEPTH) begin
            d = DATA_W'($urandom_range(0, 255));
            exp_q.push_back({ADDR_W'(wr), d});
            wr++;
            drive_sample(d);
        end
        finish_check(16'd2, "t6");
        check("t6_drops", 32'(bus.drop_cnt), 32'd0);
        bus.enable = 1'b0;
`endif

        repeat (5) step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
